// File: rtl/motoro3_pkg.sv
// Shared motoro3 definitions: capture FSM encoding, default widths, PWM clock
// rate and the posLostAbs saturation value.
package motoro3_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } cap_state_e;

  localparam int unsigned CNT_W_DEF  = 12;
  localparam int unsigned ACC_W_DEF  = 16;
  localparam int unsigned PWM_CLK_HZ = 10_000_000;
  localparam logic [15:0] ABS_SAT    = 16'h7FFF;

endpackage

// File: rtl/motoro3_edge_sync.sv
// Two-flop synchronizer, optional glitch filter and rise/fall pulses for the
// sensed PWM. Filter is built when MOTORO3_PWM_CAP_GLITCH_FILTER_EN is defined.
module motoro3_edge_sync #(
  parameter int unsigned GLITCH_LEN = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic pwm_raw,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic       pwm_d;
  logic [2:0] warm;

  if (GLITCH_LEN == 0) begin : g_bad_glitch_len
    $error("GLITCH_LEN must be at least 1");
  end

`ifdef MOTORO3_PWM_CAP_GLITCH_FILTER_EN
  localparam logic [2:0]  WARM_DONE = 3'd4;
  localparam int unsigned GW        = $clog2(GLITCH_LEN + 1);

  logic          filt;
  logic [GW-1:0] gcnt;

  always_ff @(negedge clk) begin
    if (!n_rst) begin
      filt <= 1'b0;
      gcnt <= '0;
    end else if (warm < 3'd3) begin
      filt <= s2;
      gcnt <= '0;
    end else if (s2 == filt) begin
      gcnt <= '0;
    end else if (gcnt == GW'(GLITCH_LEN - 1)) begin
      filt <= s2;
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + 1'b1;
    end
  end

  assign pwm_s = filt;
`else
  localparam logic [2:0] WARM_DONE = 3'd3;

  assign pwm_s = s2;
`endif

  always_ff @(negedge clk) begin
    if (!n_rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      pwm_d <= 1'b0;
      warm  <= '0;
    end else begin
      s1    <= pwm_raw;
      s2    <= s1;
      pwm_d <= pwm_s;
      if (warm != WARM_DONE) warm <= warm + 1'b1;
    end
  end

  // Edges are masked until the chain holds real samples, so a level already
  // present when reset releases is not mistaken for a fresh edge.
  assign rise = (warm == WARM_DONE) &&  pwm_s && !pwm_d;
  assign fall = (warm == WARM_DONE) && !pwm_s &&  pwm_d;

endmodule

// File: rtl/motoro3_pwm_capture.sv
// motoro3 PWM capture: per-cycle on/period measurement, per-step on-time
// accumulation, lost-position report and stuck detection.
// Optional glitch filter: MOTORO3_PWM_CAP_GLITCH_FILTER_EN.
module motoro3_pwm_capture
  import motoro3_pkg::*;
#(
  parameter int unsigned      CNT_W      = CNT_W_DEF,
  parameter int unsigned      ACC_W      = ACC_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT    = CNT_W'(4095),
  parameter int unsigned      GLITCH_LEN = 3
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             pwmIn,
  input  logic             capEnable,
  input  logic             stepFirst,
  input  logic             stepLast,
  input  logic [ACC_W-1:0] posWant,
  output logic [CNT_W-1:0] onLen,
  output logic [CNT_W-1:0] periodLen,
  output logic             cycValid,
  output logic [ACC_W-1:0] posReal,
  output logic [ACC_W-1:0] posLost,
  output logic [ACC_W-1:0] posLostAbs,
  output logic             stepValid,
  output logic             stuckHigh,
  output logic             stuckLow
);

  localparam logic [ACC_W-1:0] LOST_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] LOST_SAT =
    (ACC_W == 16) ? ACC_W'(ABS_SAT) : {1'b0, {(ACC_W-1){1'b1}}};

  cap_state_e       state;
  logic             pwm_s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] on_inc;
  logic [CNT_W-1:0] per_inc;
  logic [ACC_W-1:0] pos_acc;
  logic [ACC_W-1:0] acc_inc;
  logic [ACC_W-1:0] lost_next;
  logic [ACC_W-1:0] abs_next;

  motoro3_edge_sync #(.GLITCH_LEN(GLITCH_LEN)) u_edge (
    .clk    (clk),
    .n_rst  (nRst),
    .pwm_raw(pwmIn),
    .pwm_s  (pwm_s),
    .rise   (rise),
    .fall   (fall)
  );

  assign on_inc  = (on_cnt  == '1) ? on_cnt  : on_cnt  + 1'b1;
  assign per_inc = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;

  // acc_inc includes the current clock, so stepLast latches it before a
  // coincident stepFirst clear takes effect.
  always_comb begin
    acc_inc = pos_acc;
    if (state != IDLE && pwm_s && pos_acc != '1) acc_inc = pos_acc + 1'b1;
    lost_next = posWant - acc_inc;
    if (!lost_next[ACC_W-1])       abs_next = lost_next;
    else if (lost_next == LOST_MIN) abs_next = LOST_SAT;
    else                            abs_next = ~lost_next + 1'b1;
  end

  always_ff @(negedge clk) begin
    if (!nRst) begin
      state      <= IDLE;
      on_cnt     <= '0;
      per_cnt    <= '0;
      idle_cnt   <= '0;
      pos_acc    <= '0;
      onLen      <= '0;
      periodLen  <= '0;
      cycValid   <= 1'b0;
      posReal    <= '0;
      posLost    <= '0;
      posLostAbs <= '0;
      stepValid  <= 1'b0;
      stuckHigh  <= 1'b0;
      stuckLow   <= 1'b0;
    end else begin
      cycValid  <= 1'b0;
      stepValid <= 1'b0;
      if (stepLast) begin
        posReal    <= acc_inc;
        posLost    <= lost_next;
        posLostAbs <= abs_next;
        stepValid  <= 1'b1;
      end
      if (rise || fall) begin
        stuckHigh <= 1'b0;
        stuckLow  <= 1'b0;
      end
      if (!capEnable) begin
        state    <= IDLE;
        on_cnt   <= '0;
        per_cnt  <= '0;
        idle_cnt <= '0;
        pos_acc  <= '0;
      end else begin
        pos_acc <= stepFirst ? {{(ACC_W-1){1'b0}}, pwm_s} : acc_inc;
        if (state == IDLE || rise || fall) begin
          idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT) begin
          idle_cnt <= idle_cnt + 1'b1;
          if (idle_cnt == TIMEOUT - 1'b1) begin
            stuckHigh <= pwm_s;
            stuckLow  <= !pwm_s;
            onLen     <= pwm_s ? '1 : '0;
            periodLen <= '1;
            cycValid  <= 1'b1;
          end
        end
        case (state)
          IDLE: begin
            state   <= WAIT_RISE;
            on_cnt  <= '0;
            per_cnt <= '0;
          end
          WAIT_RISE: begin
            if (rise) begin
              state   <= HIGH;
              on_cnt  <= CNT_W'(1);
              per_cnt <= CNT_W'(1);
            end
          end
          HIGH: begin
            per_cnt <= per_inc;
            if (fall) state  <= LOW;
            else      on_cnt <= on_inc;
          end
          LOW: begin
            if (rise) begin
              state     <= HIGH;
              onLen     <= on_cnt;
              periodLen <= per_cnt;
              cycValid  <= 1'b1;
              on_cnt    <= CNT_W'(1);
              per_cnt   <= CNT_W'(1);
            end else begin
              per_cnt <= per_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Scoreboard bench for motoro3_pwm_capture: stimulus pushes expected cycle
// and step reports, a monitor pops them on cycValid/stepValid.
module tb_motoro3_pwm_capture;

  typedef struct {
    logic [11:0] on;
    logic [11:0] per;
  } cyc_t;

  typedef struct {
    logic [15:0] pr;
    logic [15:0] pl;
    logic [15:0] pa;
  } step_t;

  logic        clk;
  logic        nRst;
  logic        pwmIn;
  logic        capEnable;
  logic        stepFirst;
  logic        stepLast;
  logic [15:0] posWant;
  logic [11:0] onLen;
  logic [11:0] periodLen;
  logic        cycValid;
  logic [15:0] posReal;
  logic [15:0] posLost;
  logic [15:0] posLostAbs;
  logic        stepValid;
  logic        stuckHigh;
  logic        stuckLow;

  cyc_t  cyc_q[$];
  step_t step_q[$];
  cyc_t  prev;
  cyc_t  ce;
  step_t se;
  bit    armed;
  int    total;
  int    bad;

  motoro3_pwm_capture dut (
    .clk       (clk),
    .nRst      (nRst),
    .pwmIn     (pwmIn),
    .capEnable (capEnable),
    .stepFirst (stepFirst),
    .stepLast  (stepLast),
    .posWant   (posWant),
    .onLen     (onLen),
    .periodLen (periodLen),
    .cycValid  (cycValid),
    .posReal   (posReal),
    .posLost   (posLost),
    .posLostAbs(posLostAbs),
    .stepValid (stepValid),
    .stuckHigh (stuckHigh),
    .stuckLow  (stuckLow)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero();
    check("rst_onLen", 32'(onLen), 0);
    check("rst_periodLen", 32'(periodLen), 0);
    check("rst_cycValid", 32'(cycValid), 0);
    check("rst_posReal", 32'(posReal), 0);
    check("rst_posLost", 32'(posLost), 0);
    check("rst_posLostAbs", 32'(posLostAbs), 0);
    check("rst_stepValid", 32'(stepValid), 0);
    check("rst_stuckHigh", 32'(stuckHigh), 0);
    check("rst_stuckLow", 32'(stuckLow), 0);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    if (cycValid === 1'b1) begin
      if (cyc_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cyc_unexpected: got onLen=%0h periodLen=%0h want no pulse", onLen, periodLen);
      end else begin
        ce = cyc_q.pop_front();
        check("onLen", 32'(onLen), 32'(ce.on));
        check("periodLen", 32'(periodLen), 32'(ce.per));
      end
    end
    if (stepValid === 1'b1) begin
      if (step_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL step_unexpected: got posReal=%0h want no pulse", posReal);
      end else begin
        se = step_q.pop_front();
        check("posReal", 32'(posReal), 32'(se.pr));
        check("posLost", 32'(posLost), 32'(se.pl));
        check("posLostAbs", 32'(posLostAbs), 32'(se.pa));
      end
    end
  end

  // One PWM cycle; optional step pulses in its low phase and reset pulse at rst_at.
  task automatic pwm_cycle(input int high, input int period, input bit sf, input bit sl,
                           input logic [15:0] want, input step_t exp_s, input int rst_at);
    for (int i = 0; i < period; i++) begin
      if (sl && i == high + 9) check("step_latency", 32'(stepValid), 1);
      if (rst_at >= 0 && i == rst_at + 1) check_all_zero();
      pwmIn     = (i < high);
      stepFirst = sf && (i == high + 8);
      stepLast  = sl && (i == high + 8);
      posWant   = want;
      nRst      = !(rst_at >= 0 && i == rst_at);
      if (i == 0) begin
        if (armed) cyc_q.push_back(prev);
        armed = 1'b1;
        prev  = '{on: 12'(high), per: 12'(period)};
      end
      if (sl && i == high + 8) step_q.push_back(exp_s);
      if (rst_at >= 0 && i == rst_at) armed = 1'b0;
      @(posedge clk);
    end
    stepFirst = 1'b0;
    stepLast  = 1'b0;
  endtask

  step_t none;
  step_t g_exp;

  initial begin
    total     = 0;
    bad       = 0;
    armed     = 1'b0;
    none      = '{pr: 16'h0, pl: 16'h0, pa: 16'h0};
    nRst      = 1'b0;
    capEnable = 1'b0;
    pwmIn     = 1'b0;
    stepFirst = 1'b0;
    stepLast  = 1'b0;
    posWant   = 16'h0;
    repeat (3) @(posedge clk);
    check_all_zero();
    nRst      = 1'b1;
    capEnable = 1'b1;
    repeat (10) @(posedge clk);

    // 256/4095 cycles; step of 10 full cycles, want 2560.
    pwm_cycle(256, 4095, 1'b1, 1'b0, 16'd0, none, -1);
    for (int k = 1; k < 10; k++) pwm_cycle(256, 4095, 1'b0, 1'b0, 16'd0, none, -1);
    pwm_cycle(256, 4095, 1'b1, 1'b1, 16'd2560, '{pr: 16'd2560, pl: 16'h0000, pa: 16'h0000}, -1);

    // Shorter period for further steps, each 10 highs of 256.
    for (int k = 0; k < 9; k++) pwm_cycle(256, 512, 1'b0, 1'b0, 16'd0, none, -1);
    pwm_cycle(256, 512, 1'b1, 1'b1, 16'd2600, '{pr: 16'd2560, pl: 16'h0028, pa: 16'h0028}, -1);
    for (int k = 0; k < 9; k++) pwm_cycle(256, 512, 1'b0, 1'b0, 16'd0, none, -1);
    pwm_cycle(256, 512, 1'b1, 1'b1, 16'd2500, '{pr: 16'd2560, pl: 16'hFFC4, pa: 16'h003C}, -1);
    for (int k = 0; k < 9; k++) pwm_cycle(256, 512, 1'b0, 1'b0, 16'd0, none, -1);
    pwm_cycle(256, 512, 1'b0, 1'b1, 16'h8A00, '{pr: 16'd2560, pl: 16'h8000, pa: 16'h7FFF}, -1);

    // Stuck high: previous cycle report, then the timeout report.
    pwmIn = 1'b1;
    cyc_q.push_back(prev);
    cyc_q.push_back('{on: 12'hFFF, per: 12'hFFF});
    for (int i = 0; i < 5000; i++) begin
      if (i == 4000) check("stuckHigh_early", 32'(stuckHigh), 0);
      if (i == 4200) begin
        check("stuckHigh_set", 32'(stuckHigh), 1);
        check("stuckLow_clear", 32'(stuckLow), 0);
      end
      @(posedge clk);
    end
    pwmIn = 1'b0;
    repeat (20) @(posedge clk);
    check("stuckHigh_released", 32'(stuckHigh), 0);
    check("stuckLow_after_fall", 32'(stuckLow), 0);
    capEnable = 1'b0;
    armed     = 1'b0;
    repeat (5) @(posedge clk);
    check("idle_hold_onLen", 32'(onLen), 32'hFFF);
    check("idle_hold_periodLen", 32'(periodLen), 32'hFFF);

    // Reset mid-HIGH: partial measurement discarded, two more rises needed.
    capEnable = 1'b1;
    repeat (5) @(posedge clk);
    pwm_cycle(100, 300, 1'b0, 1'b0, 16'd0, none, -1);
    pwm_cycle(100, 300, 1'b0, 1'b0, 16'd0, none, -1);
    pwm_cycle(100, 300, 1'b0, 1'b0, 16'd0, none, 50);
    for (int k = 0; k < 3; k++) pwm_cycle(100, 300, 1'b0, 1'b0, 16'd0, none, -1);

    // 2-clock glitch inside a step from a fresh enable.
    capEnable = 1'b0;
    armed     = 1'b0;
    repeat (3) @(posedge clk);
    capEnable = 1'b1;
    repeat (10) @(posedge clk);
    stepFirst = 1'b1;
    @(posedge clk);
    stepFirst = 1'b0;
    repeat (5) @(posedge clk);
    pwmIn = 1'b1;
    repeat (2) @(posedge clk);
    pwmIn = 1'b0;
    repeat (20) @(posedge clk);
`ifdef MOTORO3_PWM_CAP_GLITCH_FILTER_EN
    g_exp = '{pr: 16'd0, pl: 16'd5, pa: 16'd5};
`else
    g_exp = '{pr: 16'd2, pl: 16'd3, pa: 16'd3};
`endif
    posWant  = 16'd5;
    stepLast = 1'b1;
    step_q.push_back(g_exp);
    @(posedge clk);
    stepLast = 1'b0;
    repeat (3) @(posedge clk);
    check("glitch_onLen_kept", 32'(onLen), 32'd100);
    check("glitch_periodLen_kept", 32'(periodLen), 32'd300);
    capEnable = 1'b0;
    repeat (10) @(posedge clk);
    check("cyc_queue_drained", 32'(cyc_q.size()), 0);
    check("step_queue_drained", 32'(step_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motoro3_pwm_capture.md
Name: motoro3_pwm_capture

Overview:
Receiver-side counterpart of the motoro3 PWM generator. It samples a PWM waveform (gate-sense feedback of one phase), measures on-time and period of every PWM cycle, and accumulates on-time across a commutation step. At step end it reports the position lost against the generator's wanted count. It sits beside the generator in each phase path and feeds the step/lost-position monitor.

Parameters:
- CNT_W, 12: width of the per-cycle on/period counters (saturating).
- ACC_W, 16: width of the per-step on-time accumulator.
- TIMEOUT, 12'd4095: clocks without any edge before the stuck condition is declared.
- GLITCH_LEN, 3: stability length in clocks used by the optional glitch filter.

Ports:
- clk  in  1  system clock, 10 MHz; all state updates on the falling edge, same as the generator.
- nRst  in  1  reset, synchronous, active-low.
- pwmIn  in  1  sensed PWM, asynchronous to clk.
- capEnable  in  1  0 = block held idle, counters cleared.
- stepFirst  in  1  one-clock pulse at commutation step start (m3cntFirst2 timing).
- stepLast  in  1  one-clock pulse at step end (m3cntLast2 timing).
- posWant  in  ACC_W  wanted on-count for the step; sampled on stepLast.
- onLen  out  CNT_W  last complete cycle's high time.
- periodLen  out  CNT_W  last complete cycle's rising-to-rising period.
- cycValid  out  1  one-clock pulse when onLen/periodLen update.
- posReal  out  ACC_W  on-time accumulated over the last step.
- posLost  out  ACC_W  posWant − posReal, two's complement.
- posLostAbs  out  ACC_W  magnitude of posLost, saturated at 16'h7FFF.
- stepValid  out  1  one-clock pulse when posReal/posLost update.
- stuckHigh  out  1  level: no edge for TIMEOUT clocks while high.
- stuckLow  out  1  level: no edge for TIMEOUT clocks while low.

Behaviour:
- Reset: synchronous, nRst sampled low → every output is 0. FSM goes to IDLE. All counters and the synchronizer clear. A reset asserted mid-cycle discards the partial measurement.
- Input synchronizer: pwmIn passes through 2 flops to give pwmS, plus one more flop for edge detect. Rise/fall detect latency is 3 clocks from the pwmIn change.
- FSM states:
  - IDLE → WAIT_RISE when capEnable=1.
  - WAIT_RISE → HIGH on rise. periodCnt=1 and onCnt=1 at this transition.
  - HIGH: onCnt++ and periodCnt++. Fall → LOW.
  - LOW: periodCnt++. Rise → HIGH. On that rise, onLen←onCnt, periodLen←periodCnt, cycValid=1, and both counters restart at 1.
  - Any state → IDLE on capEnable=0. Outputs keep their last values; the accumulator clears.
- The first partial cycle after WAIT_RISE is never reported. cycValid first fires on the second rise.
- Saturation: onCnt and periodCnt saturate at all-ones and never wrap.
- Accumulator posAcc:
  - Increments each clock pwmS=1 while not IDLE, saturating at all-ones.
  - stepFirst clears posAcc to 0, or to 1 if pwmS=1 that clock.
- On stepLast, on the next clock:
  - posReal←posAcc (including the stepLast clock's contribution).
  - posLost←posWant−posReal, computed modulo 2^ACC_W.
  - posLostAbs←|posLost|, using the exact negation ~x+1, with 16'h8000 mapped to 16'h7FFF.
  - stepValid=1.
- stepFirst and stepLast in the same clock: stepLast latches the old accumulator first, then the clear applies.
- Stuck detect:
  - The idle counter resets on any edge or in IDLE.
  - At TIMEOUT, stuckHigh=pwmS and stuckLow=!pwmS. The flag holds until the next edge.
  - On a stuck condition, onLen=periodLen=all-ones (high) or onLen=0 and periodLen=all-ones (low), with one cycValid pulse.
- cycValid and stepValid may coincide.

Optional Feature:
MOTORO3_PWM_CAP_GLITCH_FILTER_EN
- Defined: pwmS changes only after the synchronized input differs from pwmS for GLITCH_LEN consecutive clocks. Edge latency becomes 3+GLITCH_LEN clocks. Pulses shorter than GLITCH_LEN are ignored entirely and are not counted in posAcc.
- Undefined: the filter is absent and the latency is 3 clocks.

Decomposition:
- Shared package motoro3_pkg holds:
  - FSM state encoding: IDLE=0, WAIT_RISE=1, HIGH=2, LOW=3.
  - Default CNT_W/ACC_W.
  - The PWM clock constant of 10 MHz.
  - The abs-saturation constant 16'h7FFF.
- One sub-module, motoro3_edge_sync: synchronizer + optional glitch filter + rise/fall pulses.

Test Plan:
- Ideal PWM, high 256 clk of period 4095, capEnable=1 → from the second rise, cycValid every 4095 clk with onLen=256 and periodLen=4095.
- stepFirst, then 10 full cycles of 256/4095, then stepLast, posWant=2560 → posReal=2560, posLost=0, stepValid one clock later.
- Same as above but posWant=2600 → posLost=40, posLostAbs=40. posWant=2500 → posLost=16'hFFC4, posLostAbs=60.
- pwmIn held high 5000 clk → stuckHigh rises at TIMEOUT after the last edge, onLen=periodLen=12'hFFF. A later fall clears stuckHigh.
- nRst low for 1 clock mid-HIGH → all outputs 0 next clock, no cycValid until two further rises.
- With MOTORO3_PWM_CAP_GLITCH_FILTER_EN, inject 2-clk high pulses into a low period → no edge, onLen unchanged, posAcc unaffected. Without the macro, the pulse is counted.
